// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
//   state_t : controller states (IDLE: output held low, RUN: dividing,
//             PEND: new divisor held until the current period ends)
//   MIN_DIV : smallest divisor that yields a meaningful clock
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_core.sv
// Counter datapath that turns clk into a 50%-duty divided clock for any
// divisor >= 2. A posedge counter sets the first div/2 cycles high; for odd
// divisors a negedge copy of that phase adds the missing half cycle.
//   clk     : source clock
//   rst     : asynchronous active-low reset
//   run     : keep counting into the next cycle; low clears the datapath
//   restart : start a fresh period (phase 0) at the next edge
//   div     : divisor in use
//   wrap    : high in the last cycle of a period (pos_cnt == div-1)
//   clk_out : divided clock
module clk_div_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             restart,
  input  logic [CNT_W-1:0] div,
  output logic             wrap,
  output logic             clk_out
);

  logic [CNT_W-1:0] pos_cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic [CNT_W-1:0] half;
  logic             pos_hi;
  logic             neg_hi;

  assign half = div >> 1;
  assign wrap = (pos_cnt == div - CNT_W'(1));

  always_comb begin
    nxt_cnt = pos_cnt + CNT_W'(1);
    if (restart || wrap) begin
      nxt_cnt = '0;
    end
  end

  // pos_hi is registered from the next count so it lines up with pos_cnt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_cnt <= '0;
      pos_hi  <= 1'b0;
    end else if (!run) begin
      pos_cnt <= '0;
      pos_hi  <= 1'b0;
    end else begin
      pos_cnt <= nxt_cnt;
      pos_hi  <= (nxt_cnt < half);
    end
  end

  // Half-cycle delayed copy; only contributes for odd divisors.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      neg_hi <= 1'b0;
    end else begin
      neg_hi <= pos_hi;
    end
  end

  assign clk_out = pos_hi | (div[0] & neg_hi);

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider controller. Accepts a new divisor over
// a valid/ready handshake and only switches at a period boundary, so the
// divided clock never sees a truncated or stretched period.
//   clk       : source clock
//   rst       : asynchronous active-low reset
//   en        : enable divider output
//   div_in    : requested divisor N
//   div_valid : div_in valid
//   div_ready : controller can accept div_in (low while a change is pending)
//   cur_div   : divisor currently driving clk_out
//   busy      : divisor change pending
//   err       : one-cycle pulse, divisor below MIN_DIV rejected
//   clk_out   : divided clock
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic [CNT_W-1:0] cur_div,
  output logic             busy,
  output logic             err,
  output logic             clk_out
);

  state_t           state;
  logic [CNT_W-1:0] pend_div;
  logic             restart;
  logic             xfer;
  logic             legal;
  logic             wrap;
  logic             run;

  assign xfer  = div_valid & div_ready;
  assign legal = (div_in >= CNT_W'(MIN_DIV));

  // Stop the datapath at the boundary edge itself when en is low, so no new
  // period begins.
  assign run = (state != IDLE) & ~(wrap & ~en);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur_div   <= CNT_W'(DEFAULT_DIV);
      pend_div  <= '0;
      restart   <= 1'b0;
      div_ready <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err     <= xfer & ~legal;
      restart <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer && legal) begin
            cur_div <= div_in;
          end
          // One idle-looking cycle before the first period starts.
          if (en) begin
            state   <= RUN;
            restart <= 1'b1;
          end
        end
        RUN: begin
          if (wrap && !en) begin
            // Nothing is running afterwards, so a divisor arriving now can
            // be taken directly.
            state <= IDLE;
            if (xfer && legal) begin
              cur_div <= div_in;
            end
          end else if (xfer && legal && (div_in != cur_div)) begin
            // A boundary in this same cycle is deliberately skipped.
            pend_div  <= div_in;
            state     <= PEND;
            busy      <= 1'b1;
            div_ready <= 1'b0;
          end
        end
        PEND: begin
          if (wrap) begin
            cur_div   <= pend_div;
            busy      <= 1'b0;
            div_ready <= 1'b1;
            state     <= en ? RUN : IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          div_ready <= 1'b1;
        end
      endcase
    end
  end

  clk_div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .restart (restart),
    .div     (cur_div),
    .wrap    (wrap),
    .clk_out (clk_out)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl. The reference model tracks the divider
// as "periods of N cycles, high for the first N half-cycles"; each cycle's
// expected outputs are queued and a monitor compares them against the DUT.
module tb_clk_div_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] div_in;
  logic       div_valid;
  logic       div_ready;
  logic [7:0] cur_div;
  logic       busy;
  logic       err;
  logic       clk_out;

  clk_div_ctrl #(
    .CNT_W       (8),
    .DEFAULT_DIV (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .cur_div   (cur_div),
    .busy      (busy),
    .err       (err),
    .clk_out   (clk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cd;
    bit bsy;
    bit rdy;
    bit er;
    bit h1;
    bit h2;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  // Reference model state
  bit m_active;
  bit m_delay;
  bit m_pv;
  bit m_err;
  int m_phase;
  int m_n;
  int m_pend;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_delay  = 0;
    m_pv     = 0;
    m_err    = 0;
    m_phase  = 0;
    m_n      = 3;
    m_pend   = 0;
  endtask

  task automatic model_step(input bit e, input bit v, input int d);
    bit   xfer;
    bit   legal;
    bit   bnd;
    bit   on;
    exp_t x;
    xfer  = v && !m_pv;
    legal = (d >= 2);
    bnd   = m_active && !m_delay && (m_phase == m_n - 1);
    m_err = xfer && !legal;
    if (!m_active) begin
      if (xfer && legal) m_n = d;
      if (e) begin
        m_active = 1;
        m_delay  = 1;
        m_phase  = 0;
      end
    end else if (m_delay) begin
      m_delay = 0;
      m_phase = 0;
      if (xfer && legal && d != m_n) begin
        m_pv   = 1;
        m_pend = d;
      end
    end else if (m_pv) begin
      if (bnd) begin
        m_n     = m_pend;
        m_pv    = 0;
        m_phase = 0;
        if (!e) m_active = 0;
      end else begin
        m_phase++;
      end
    end else begin
      if (bnd && !e) begin
        m_active = 0;
        m_phase  = 0;
        if (xfer && legal) m_n = d;
      end else begin
        m_phase = bnd ? 0 : m_phase + 1;
        if (xfer && legal && d != m_n) begin
          m_pv   = 1;
          m_pend = d;
        end
      end
    end
    on    = m_active && !m_delay;
    x.cd  = m_n;
    x.bsy = m_pv;
    x.rdy = !m_pv;
    x.er  = m_err;
    x.h1  = on && (2 * m_phase < m_n);
    x.h2  = on && (2 * m_phase + 1 < m_n);
    exp_q.push_back(x);
  endtask

  // Called at posedge+2; drives inputs for the next edge.
  task automatic drive(input bit e, input bit v, input int d);
    en        = e;
    div_valid = v;
    div_in    = 8'(d);
    @(posedge clk);
    model_step(e, v, d);
    #2;
  endtask

  // Monitor: first half sampled after posedge, second half after negedge.
  initial begin
    logic       a1;
    logic       a2;
    logic [7:0] acd;
    logic       ab;
    logic       ar;
    logic       ae;
    exp_t       x;
    forever begin
      @(posedge clk);
      #1;
      a1  = clk_out;
      acd = cur_div;
      ab  = busy;
      ar  = div_ready;
      ae  = err;
      @(negedge clk);
      #1;
      a2 = clk_out;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("clk_out_first_half", int'(a1), int'(x.h1));
        chk("clk_out_second_half", int'(a2), int'(x.h2));
        chk("cur_div", int'(acd), x.cd);
        chk("busy", int'(ab), int'(x.bsy));
        chk("div_ready", int'(ar), int'(x.rdy));
        chk("err", int'(ae), int'(x.er));
      end
    end
  end

  task automatic check_reset_values();
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_cur_div", int'(cur_div), 3);
    chk("rst_div_ready", int'(div_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
  endtask

  initial begin
    bit pre;
    bit e_state;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    en        = 1'b1;
    div_valid = 1'b0;
    div_in    = 8'd0;
    model_reset();
    #1 rst = 1'b0;
    #2 check_reset_values();
    @(posedge clk);
    #2 rst = 1'b1;

    // Default divisor 3 straight out of reset
    repeat (12) drive(1, 0, 0);

    // Switch to 4 mid-period
    drive(1, 0, 0);
    drive(1, 1, 4);
    repeat (12) drive(1, 0, 0);

    // Illegal divisors
    drive(1, 1, 1);
    repeat (3) drive(1, 0, 0);
    drive(1, 1, 0);
    repeat (3) drive(1, 0, 0);

    // Equal divisor is a no-op
    drive(1, 1, 4);
    repeat (3) drive(1, 0, 0);

    // 6 then 8 held back-to-back
    drive(1, 1, 6);
    for (int i = 0; i < 50; i++) begin
      pre = m_pv;
      drive(1, 1, 8);
      if (!pre) break;
    end
    repeat (20) drive(1, 0, 0);

    // Divisor 5, then drop en mid-period
    drive(1, 1, 5);
    repeat (14) drive(1, 0, 0);
    repeat (2) drive(1, 0, 0);
    repeat (12) drive(0, 0, 0);
    drive(0, 1, 2);
    repeat (2) drive(0, 0, 0);
    repeat (10) drive(1, 0, 0);
    drive(1, 1, 3);
    repeat (10) drive(1, 0, 0);

    // Async reset during the high phase
    for (int i = 0; i < 40; i++) begin
      drive(1, 0, 0);
      if (m_active && !m_delay && m_phase == 0) break;
    end
    #5;
    chk("pre_reset_clk_out_high", int'(clk_out), 1);
    rst = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (4) drive(0, 0, 0);
    repeat (8) drive(1, 0, 0);

    // Randomized traffic
    e_state = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) e_state = !e_state;
      drive(e_state, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 12)));
    end
    repeat (30) drive(1, 0, 0);

    @(posedge clk);
    #8;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
